// File: rtl/edge_event_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : edge_sched_pkg
// Brief   : Shared types and round-robin pick helper for edge_event_sched.
// Revision: 1.0
// ============================================================================
package edge_sched_pkg;

    localparam int MAX_CH = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first set bit of pend searching upward from last+1, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                         input logic [IDX_W-1:0]  last,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned c;
        r = '0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            c = ({28'd0, last} + k) % n;
            if (k <= n && !r.found && pend[c[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : edge_event_sched_if
// Brief   : Registered valid/ready event port of edge_event_sched.
// Revision: 1.0
// ============================================================================
interface edge_event_sched_if #(
    parameter int NUM_CH = 4
);
    localparam int ID_W = $clog2(NUM_CH);

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;
    logic            evt_ready;

    modport master (output evt_valid, evt_id, evt_rise, input  evt_ready);
    modport slave  (input  evt_valid, evt_id, evt_rise, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/edge_event_sched_chan.sv
`default_nettype none
// ============================================================================
// Module  : edge_chan
// Brief   : One channel: 2-flop synchronizer, history flop, edge classifier.
// Revision: 1.0
// ============================================================================
module edge_chan #(
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       n_rst,
    input  wire logic       i_async,
    input  wire logic [1:0] i_mode,
    output logic            o_hit,
    output logic            o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_h;
    logic w_fall;

    // History runs regardless of mode so a mode change cannot fabricate an edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_h  <= RST_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_h  <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_h;
    assign w_fall = ~r_s2 & r_h;
    assign o_hit  = (o_rise & i_mode[0]) | (w_fall & i_mode[1]);

endmodule
`default_nettype wire

// File: rtl/edge_event_sched.sv
`default_nettype none
// ============================================================================
// Module  : edge_event_sched
// Brief   : Per-channel edge capture with round-robin serialisation of events.
// Revision: 1.0
// ============================================================================
module edge_event_sched
    import edge_sched_pkg::*;
#(
    parameter int   NUM_CH  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic                clk,
    input  wire logic                n_rst,
    input  wire logic [NUM_CH-1:0]   async_in,
    input  wire logic [2*NUM_CH-1:0] cfg_mode,
    input  wire logic [NUM_CH-1:0]   ovf_clr,
    edge_event_sched_if.master       evt,
    output logic [NUM_CH-1:0]        pending,
    output logic [NUM_CH-1:0]        ovf
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_pol;
    logic [NUM_CH-1:0] r_ovf;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic              r_rise;
    logic [ID_W-1:0]   r_last;

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_mode_off;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_ovf_set;
    logic              w_slot_free;
    logic [MAX_CH-1:0] w_pend_ext;
    logic [IDX_W-1:0]  w_last_ext;
    rr_pick_t          w_pick;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            edge_chan #(
                .RST_VAL (RST_VAL)
            ) u_chan (
                .clk     (clk),
                .n_rst   (n_rst),
                .i_async (async_in[i]),
                .i_mode  (cfg_mode[2*i +: 2]),
                .o_hit   (w_hit[i]),
                .o_rise  (w_rise[i])
            );
            assign w_mode_off[i] = (edge_mode_t'(cfg_mode[2*i +: 2]) == MODE_OFF);
            assign w_grant[i]    = w_slot_free & w_pick.found & (w_pick.idx == IDX_W'(i));
        end
    endgenerate

    assign w_slot_free = ~r_valid | evt.evt_ready;
    assign w_ovf_set   = w_hit & r_pending & ~w_grant;

    // Arbitration looks only at registered pending flags, never at same-cycle hits.
    always_comb begin
        w_pend_ext                 = '0;
        w_pend_ext[NUM_CH-1:0]     = r_pending;
        w_last_ext                 = '0;
        w_last_ext[ID_W-1:0]       = r_last;
        w_pick                     = rr_pick(w_pend_ext, w_last_ext, NUM_CH);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pending <= '0;
            r_pol     <= '0;
            r_ovf     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_mode_off[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (w_hit[i]) begin
                    // A hit on an ungranted pending channel is an overflow; newer polarity wins.
                    r_pending[i] <= 1'b1;
                    r_pol[i]     <= w_rise[i];
                end else if (w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end
                if (w_ovf_set[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    r_ovf[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rise  <= 1'b0;
            r_last  <= ID_W'(NUM_CH - 1);
        end else if (w_slot_free) begin
            r_valid <= w_pick.found;
            if (w_pick.found) begin
                r_id   <= w_pick.idx[ID_W-1:0];
                r_rise <= |(r_pol & w_grant);
                r_last <= w_pick.idx[ID_W-1:0];
            end
        end
    end

    assign evt.evt_valid = r_valid;
    assign evt.evt_id    = r_id;
    assign evt.evt_rise  = r_rise;
    assign pending       = r_pending;
    assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_edge_event_sched
// Brief   : Directed plus random stimulus against a cycle-level event model.
// Revision: 1.0
// ============================================================================
module tb_edge_event_sched;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [NCH-1:0] async_in;
    logic [2*NCH-1:0] cfg_mode;
    logic [NCH-1:0] ovf_clr;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] ovf;

    logic [NCH-1:0]   async1 = 4'hF;
    logic [2*NCH-1:0] cfg1   = 8'hFF;
    logic [NCH-1:0]   clr1   = 4'h0;
    logic [NCH-1:0]   pending1;
    logic [NCH-1:0]   ovf1;

    int n_chk  = 0;
    int n_pass = 0;

    edge_event_sched_if #(.NUM_CH(NCH)) u_if ();
    edge_event_sched_if #(.NUM_CH(NCH)) u_if1 ();

    edge_event_sched #(.NUM_CH(NCH), .RST_VAL(1'b0)) u_dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (async_in),
        .cfg_mode (cfg_mode),
        .ovf_clr  (ovf_clr),
        .evt      (u_if),
        .pending  (pending),
        .ovf      (ovf)
    );

    edge_event_sched #(.NUM_CH(NCH), .RST_VAL(1'b1)) u_dut1 (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (async1),
        .cfg_mode (cfg1),
        .ovf_clr  (clr1),
        .evt      (u_if1),
        .pending  (pending1),
        .ovf      (ovf1)
    );

    always #5 clk = ~clk;

    // Model: the channel sees the input as sampled 2 and 3 edges ago.
    bit [NCH-1:0] m_smp1, m_smp2, m_smp3;
    bit [NCH-1:0] m_pend, m_pol, m_ovf;
    bit           m_valid, m_rise;
    int           m_id, m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step();
        bit [NCH-1:0] np, npol, novf;
        bit           rd, fd, hit, free;
        int           g, md, c;
        if (!n_rst) begin
            m_smp1 = '0; m_smp2 = '0; m_smp3 = '0;
            m_pend = '0; m_pol = '0; m_ovf = '0;
            m_valid = 0; m_id = 0; m_rise = 0; m_last = NCH - 1;
            return;
        end
        free = !m_valid || u_if.evt_ready;
        g = -1;
        if (free) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        np = m_pend; npol = m_pol; novf = m_ovf;
        for (int ch = 0; ch < NCH; ch++) begin
            md  = (int'(cfg_mode) >> (2 * ch)) & 3;
            rd  = m_smp2[ch] && !m_smp3[ch];
            fd  = !m_smp2[ch] && m_smp3[ch];
            hit = (rd && (md & 1) != 0) || (fd && (md & 2) != 0);
            if (ovf_clr[ch]) novf[ch] = 0;
            if (md == 0) np[ch] = 0;
            else if (hit && m_pend[ch] && g != ch) begin novf[ch] = 1; npol[ch] = rd; end
            else if (hit) begin np[ch] = 1; npol[ch] = rd; end
            else if (g == ch) np[ch] = 0;
        end
        if (free) begin
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_rise = m_pol[g]; m_last = g;
            end else begin
                m_valid = 0;
            end
        end
        m_pend = np; m_pol = npol; m_ovf = novf;
        m_smp3 = m_smp2; m_smp2 = m_smp1; m_smp1 = async_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", u_if.evt_valid, m_valid);
        if (m_valid) begin
            chk("id", u_if.evt_id, m_id);
            chk("rise", u_if.evt_rise, m_rise);
        end
        chk("pending", pending, m_pend);
        chk("ovf", ovf, m_ovf);
        chk("rv1_valid", u_if1.evt_valid, 0);
        chk("rv1_pending", pending1, 0);
    endtask

    task automatic wait_evt(input string tag, input int exp_id);
        int n = 0;
        while (u_if.evt_valid !== 1'b1 && n < 8) begin tick(); n++; end
        chk({tag, "_valid"}, u_if.evt_valid, 1);
        chk(tag, u_if.evt_id, exp_id);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0; async_in = '0; cfg_mode = '0; ovf_clr = '0;
        u_if.evt_ready = 1'b1; u_if1.evt_ready = 1'b1;
        @(posedge clk); model_step(); #1;
        tick();
        chk("rst_id", u_if.evt_id, 0);
        chk("rst_rise", u_if.evt_rise, 0);
        n_rst = 1'b1;

        // Latency: change sampled at edge 0, event visible after edge 3.
        cfg_mode = 8'h01;
        repeat (2) tick();
        async_in[0] = 1'b1;
        repeat (3) tick();
        chk("lat_valid_early", u_if.evt_valid, 0);
        chk("lat_pend", pending[0], 1);
        tick();
        chk("lat_valid", u_if.evt_valid, 1);
        chk("lat_id", u_if.evt_id, 0);
        chk("lat_rise", u_if.evt_rise, 1);
        tick();
        chk("lat_done", u_if.evt_valid, 0);

        // Simultaneous rises drain 0,1,2,3 after reset.
        async_in = '0;
        do_reset();
        cfg_mode = 8'hFF;
        repeat (2) tick();
        async_in = 4'hF;
        repeat (3) tick();
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("seq_valid", u_if.evt_valid, 1);
            chk("seq_id", u_if.evt_id, k);
        end
        tick();
        chk("seq_done", u_if.evt_valid, 0);

        // Round-robin order depends on last grant.
        async_in = 4'b1001;
        wait_evt("rr_a0", 1); tick(); wait_evt("rr_a1", 2); tick();
        async_in = 4'b1011;
        wait_evt("rr_b", 1); tick();
        async_in = 4'b1101;
        wait_evt("rr_c0", 2); tick(); wait_evt("rr_c1", 1); tick();

        // Hold under back-pressure, polarity overwrite, overflow and clear.
        u_if.evt_ready = 1'b0;
        cfg_mode = 8'h0C;
        async_in[1] = 1'b1;
        repeat (4) tick();
        chk("hold_valid", u_if.evt_valid, 1);
        async_in[1] = 1'b0;
        repeat (3) tick();
        chk("hold_pend", pending[1], 1);
        chk("hold_id", u_if.evt_id, 1);
        chk("hold_rise", u_if.evt_rise, 1);
        async_in[1] = 1'b1;
        repeat (3) tick();
        chk("ovf_set", ovf[1], 1);
        ovf_clr = 4'b0010; tick(); ovf_clr = '0;
        chk("ovf_clr", ovf[1], 0);
        async_in[1] = 1'b0;
        repeat (2) tick();
        ovf_clr = 4'b0010; tick(); ovf_clr = '0;
        chk("ovf_set_wins", ovf[1], 1);
        u_if.evt_ready = 1'b1;
        tick();
        chk("pol_valid", u_if.evt_valid, 1);
        chk("pol_fall", u_if.evt_rise, 0);
        tick();
        ovf_clr = 4'hF; tick(); ovf_clr = '0;

        // Mode off drops a pending flag without emitting it.
        u_if.evt_ready = 1'b0;
        cfg_mode = 8'h43;
        async_in[0] = 1'b0; async_in[3] = 1'b0;
        repeat (4) tick();
        chk("off_hold", u_if.evt_id, 0);
        async_in[3] = 1'b1;
        repeat (3) tick();
        chk("off_pend", pending[3], 1);
        cfg_mode = 8'h03;
        tick();
        chk("off_clear", pending[3], 0);
        u_if.evt_ready = 1'b1;
        tick();
        chk("off_noevt", u_if.evt_valid, 0);
        cfg_mode = 8'h43;
        repeat (5) tick();
        chk("restore_noevt", u_if.evt_valid, 0);

        // Reset while an event is presented and others pend.
        async_in = '0; cfg_mode = 8'hFF;
        repeat (8) tick();
        do_reset();
        u_if.evt_ready = 1'b0;
        async_in = 4'b1011;
        repeat (4) tick();
        chk("mid_valid", u_if.evt_valid, 1);
        chk("mid_pend", pending, 4'b1010);
        do_reset();
        chk("mid_rst_valid", u_if.evt_valid, 0);
        chk("mid_rst_pend", pending, 0);
        chk("mid_rst_ovf", ovf, 0);

        // Random traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_rst          = ($urandom_range(0, 399) != 0);
            u_if.evt_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 5) == 0) async_in[c] = ~async_in[c];
            if ($urandom_range(0, 31) == 0) cfg_mode = 8'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
